// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the time-multiplexed adder arbiter.
// Holds the FSM state encoding, the default parameters and the requester-ID width helper.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADD_LAT = 1;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one position after last_grant and wraps.
// Produces a one-hot grant, the matching index, and an any-request flag.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  function automatic logic [ID_W-1:0] wrap_idx(input int v);
    return ID_W'(v % NUM_REQ);
  endfunction

  // Bit 0 of rot is the requester immediately after the previous winner.
  logic [NUM_REQ-1:0] rot;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign rot[gi] = req[wrap_idx(int'(last_grant) + 1 + gi)];
  end

  int off;

  always_comb begin
    off       = 0;
    any       = |rot;
    grant     = '0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    if (any) begin
      grant_idx        = wrap_idx(int'(last_grant) + 1 + off);
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one external adder among NUM_REQ requesters, one transaction at a time.
// Flow: grant in IDLE, pulse add_en in ISSUE, wait ADD_LAT cycles, then hold the result in RESP.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int ADD_LAT = DEF_ADD_LAT,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  output logic                       add_en,
  output logic [DATA_W-1:0]          add_a,
  output logic [DATA_W-1:0]          add_b,
  input  logic [DATA_W:0]            add_sum,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [DATA_W:0]            rsp_sum,
  output logic                       busy
);

  localparam int CNT_W = $clog2(ADD_LAT + 1);

  state_t             state_reg;
  logic [DATA_W-1:0]  a_reg;
  logic [DATA_W-1:0]  b_reg;
  logic [ID_W-1:0]    id_reg;
  logic [ID_W-1:0]    last_grant_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               add_en_reg;
  logic               rsp_valid_reg;
  logic [DATA_W:0]    rsp_sum_reg;

  logic [NUM_REQ-1:0] grant_onehot;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;

  logic [DATA_W-1:0]  a_slice [NUM_REQ];
  logic [DATA_W-1:0]  b_slice [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign a_slice[gi] = req_a[gi*DATA_W +: DATA_W];
    assign b_slice[gi] = req_b[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .grant      (grant_onehot),
    .grant_idx  (grant_idx),
    .any        (grant_any)
  );

  // The accept strobe is combinational; it is also gated by reset so it reads zero while held.
  assign req_ready = (state_reg == ST_IDLE && rst) ? grant_onehot : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      a_reg          <= '0;
      b_reg          <= '0;
      id_reg         <= '0;
      last_grant_reg <= ID_W'(NUM_REQ - 1);
      cnt_reg        <= '0;
      add_en_reg     <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_sum_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_any) begin
            a_reg      <= a_slice[grant_idx];
            b_reg      <= b_slice[grant_idx];
            id_reg     <= grant_idx;
            add_en_reg <= 1'b1;
            state_reg  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          add_en_reg <= 1'b0;
          cnt_reg    <= CNT_W'(ADD_LAT);
          state_reg  <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_reg <= cnt_reg - 1'b1;
          // The adder result is valid in the last wait cycle.
          if (cnt_reg == CNT_W'(1)) begin
            rsp_sum_reg   <= add_sum;
            rsp_valid_reg <= 1'b1;
            state_reg     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg  <= 1'b0;
            last_grant_reg <= id_reg;
            state_reg      <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign add_en    = add_en_reg;
  assign add_a     = a_reg;
  assign add_b     = b_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = id_reg;
  assign rsp_sum   = rsp_sum_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: ADD_LAT=1 instance plus an ADD_LAT=3 instance, each with a pipelined adder model.
module tb_adder_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           add_en;
  logic [W-1:0]   add_a, add_b;
  logic [W:0]     add_sum;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [W:0]     rsp_sum;
  logic           busy;

  logic [N-1:0]   l3_req_valid, l3_req_ready;
  logic [N*W-1:0] l3_req_a, l3_req_b;
  logic           l3_add_en;
  logic [W-1:0]   l3_add_a, l3_add_b;
  logic [W:0]     l3_add_sum;
  logic           l3_rsp_valid, l3_rsp_ready;
  logic [1:0]     l3_rsp_id;
  logic [W:0]     l3_rsp_sum;
  logic           l3_busy;

  int n_total = 0;
  int n_bad   = 0;

  adder_arbiter #(.NUM_REQ(N), .DATA_W(W), .ADD_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_en(add_en), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy)
  );

  adder_arbiter #(.NUM_REQ(N), .DATA_W(W), .ADD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(l3_req_valid), .req_ready(l3_req_ready),
    .req_a(l3_req_a), .req_b(l3_req_b), .add_en(l3_add_en), .add_a(l3_add_a), .add_b(l3_add_b),
    .add_sum(l3_add_sum), .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready),
    .rsp_id(l3_rsp_id), .rsp_sum(l3_rsp_sum), .busy(l3_busy)
  );

  // Adder models: the sum is produced only for an enabled operation, zero otherwise.
  logic [W:0] s1_q = '0;
  logic [W:0] s3_q0 = '0, s3_q1 = '0, s3_q2 = '0;
  always @(posedge clk) begin
    s1_q  <= add_en ? ({1'b0, add_a} + {1'b0, add_b}) : '0;
    s3_q0 <= l3_add_en ? ({1'b0, l3_add_a} + {1'b0, l3_add_b}) : '0;
    s3_q1 <= s3_q0;
    s3_q2 <= s3_q1;
  end
  assign add_sum    = s1_q;
  assign l3_add_sum = s3_q2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int j = 0; j < 12; j++) begin
      if (req_ready != '0) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int j = 0; j < 12; j++) begin
      if (rsp_valid) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    l3_req_valid = '0; l3_req_a = '0; l3_req_b = '0; l3_rsp_ready = 1'b1;
    #2 rst = 1'b0;
    repeat (2) tick();
    n_total++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_total++; if (add_en !== 1'b0) begin n_bad++; $display("FAIL reset_add_en: got %b want 0", add_en); end
    n_total++; if ({add_a, add_b} !== 16'd0) begin n_bad++; $display("FAIL reset_operands: got %0d/%0d want 0/0", add_a, add_b); end
    n_total++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_total++; if (rsp_id !== 2'd0 || rsp_sum !== 9'd0) begin n_bad++; $display("FAIL reset_rsp: got id=%0d sum=%0d want 0/0", rsp_id, rsp_sum); end
    n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b1;
    #1;
    n_total++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL release_first_grant: got %b want 0001", req_ready); end
    req_valid = '0;
    tick();
    n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL release_idle_busy: got %b want 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    req_a = '0; req_b = '0;
    req_a[7:0] = 8'd200; req_b[7:0] = 8'd100;
    req_valid = 4'b0001;
    #1;
    n_total++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_accept: got %b want 0001", req_ready); end
    tick();
    n_total++; if (add_en !== 1'b1 || add_a !== 8'd200 || add_b !== 8'd100) begin n_bad++; $display("FAIL single_issue: got en=%b a=%0d b=%0d want 1/200/100", add_en, add_a, add_b); end
    n_total++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin n_bad++; $display("FAIL single_issue_ctl: got ready=%b busy=%b want 0000/1", req_ready, busy); end
    req_valid = '0;
    tick();
    n_total++; if (add_en !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_wait: got en=%b rsp_valid=%b want 0/0", add_en, rsp_valid); end
    tick();
    n_total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 9'd300) begin n_bad++; $display("FAIL single_resp: got v=%b id=%0d sum=%0d want 1/0/300", rsp_valid, rsp_id, rsp_sum); end
    n_total++; if (add_a !== 8'd200) begin n_bad++; $display("FAIL single_hold_a: got %0d want 200", add_a); end
    tick();
    n_total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_done: got v=%b busy=%b want 0/0", rsp_valid, busy); end
    $display("test_single done");
  endtask

  task automatic test_contention();
    int exp_id[5]  = '{0, 1, 2, 3, 0};
    int exp_sum[5] = '{10, 11, 12, 13, 10};
    int acc, prev_acc;
    bit ok;
    rst = 1'b0; tick(); rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(i);
      req_b[i*W +: W] = 8'd10;
    end
    req_valid = '1; rsp_ready = 1'b1;
    prev_acc = 0;
    #1;
    for (int k = 0; k < 5; k++) begin
      wait_ready(ok);
      n_total++; if (!ok || req_ready !== 4'(1 << exp_id[k])) begin n_bad++; $display("FAIL contention_grant%0d: got %b want %b", k, req_ready, 4'(1 << exp_id[k])); end
      acc = cyc;
      if (k > 0) begin
        n_total++; if (acc - prev_acc !== 4) begin n_bad++; $display("FAIL contention_spacing%0d: got %0d want 4", k, acc - prev_acc); end
      end
      prev_acc = acc;
      tick();
      wait_rsp(ok);
      n_total++; if (!ok || cyc - acc !== 3) begin n_bad++; $display("FAIL contention_latency%0d: got %0d want 3", k, cyc - acc); end
      n_total++; if (rsp_id !== 2'(exp_id[k]) || rsp_sum !== 9'(exp_sum[k])) begin n_bad++; $display("FAIL contention_rsp%0d: got id=%0d sum=%0d want %0d/%0d", k, rsp_id, rsp_sum, exp_id[k], exp_sum[k]); end
      tick();
    end
    req_valid = '0;
    wait_rsp(ok);
    tick();
    $display("test_contention done");
  endtask

  task automatic test_backpressure();
    bit ok;
    req_a = {8'd40, 8'd30, 8'd7, 8'd5};
    req_b = {8'd8, 8'd8, 8'd8, 8'd8};
    req_valid = 4'b0010; rsp_ready = 1'b0;
    #1;
    wait_ready(ok);
    n_total++; if (!ok || req_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
    tick();
    req_valid = '1;
    wait_rsp(ok);
    n_total++; if (!ok) begin n_bad++; $display("FAIL bp_rsp_timeout: got no rsp_valid want rsp_valid"); end
    for (int c = 0; c < 5; c++) begin
      n_total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 9'd15 || req_ready !== 4'b0000 || add_en !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got v=%b id=%0d sum=%0d rdy=%b en=%b want 1/1/15/0000/0", c, rsp_valid, rsp_id, rsp_sum, req_ready, add_en);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_total++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_next_grant: got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    wait_rsp(ok);
    n_total++; if (!ok || rsp_id !== 2'd2 || rsp_sum !== 9'd38) begin n_bad++; $display("FAIL bp_second: got id=%0d sum=%0d want 2/38", rsp_id, rsp_sum); end
    tick();
    $display("test_backpressure done");
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    int seen;
    req_a[31:24] = 8'd1; req_b[31:24] = 8'd2;
    req_valid = 4'b1000;
    #1;
    wait_ready(ok);
    tick();
    req_valid = '0;
    tick();
    n_total++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL riw_in_wait: got busy=%b v=%b want 1/0", busy, rsp_valid); end
    rst = 1'b0;
    #1;
    n_total++;
    if (req_ready !== 4'b0000 || add_en !== 1'b0 || add_a !== 8'd0 || add_b !== 8'd0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 9'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL riw_async_clear: got rdy=%b en=%b a=%0d b=%0d v=%b id=%0d sum=%0d busy=%b want all zero", req_ready, add_en, add_a, add_b, rsp_valid, rsp_id, rsp_sum, busy);
    end
    tick(); tick();
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
      tick();
    end
    n_total++; if (seen !== 0) begin n_bad++; $display("FAIL riw_no_stale_rsp: got %0d active cycles want 0", seen); end
    req_valid = '1;
    #1;
    n_total++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL riw_grant0: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    wait_rsp(ok);
    n_total++; if (!ok || rsp_id !== 2'd0 || rsp_sum !== 9'd13) begin n_bad++; $display("FAIL riw_after: got id=%0d sum=%0d want 0/13", rsp_id, rsp_sum); end
    tick();
    $display("test_reset_in_wait done");
  endtask

  task automatic test_carry();
    bit ok;
    req_a[23:16] = 8'd255; req_b[23:16] = 8'd255;
    req_valid = 4'b0100;
    #1;
    wait_ready(ok);
    tick();
    req_valid = '0;
    wait_rsp(ok);
    n_total++; if (!ok || rsp_id !== 2'd2 || rsp_sum !== 9'd510) begin n_bad++; $display("FAIL carry_max: got id=%0d sum=%0d want 2/510", rsp_id, rsp_sum); end
    tick();
    req_a[31:24] = 8'd0; req_b[31:24] = 8'd0;
    req_valid = 4'b1000;
    #1;
    wait_ready(ok);
    tick();
    req_valid = '0;
    wait_rsp(ok);
    n_total++; if (!ok || rsp_id !== 2'd3 || rsp_sum !== 9'd0) begin n_bad++; $display("FAIL carry_zero: got id=%0d sum=%0d want 3/0", rsp_id, rsp_sum); end
    tick();
    $display("test_carry done");
  endtask

  task automatic test_lat3();
    int acc, en_cnt;
    l3_req_a = '0; l3_req_b = '0;
    l3_req_a[7:0] = 8'd100; l3_req_b[7:0] = 8'd50;
    l3_req_valid = 4'b0001; l3_rsp_ready = 1'b1;
    #1;
    n_total++; if (l3_req_ready !== 4'b0001) begin n_bad++; $display("FAIL lat3_accept: got %b want 0001", l3_req_ready); end
    acc = cyc;
    tick();
    l3_req_valid = '0;
    en_cnt = 0;
    for (int j = 0; j < 12 && !l3_rsp_valid; j++) begin
      if (l3_add_en) en_cnt++;
      tick();
    end
    n_total++; if (l3_rsp_valid !== 1'b1 || cyc - acc !== 5) begin n_bad++; $display("FAIL lat3_latency: got %0d want 5", cyc - acc); end
    n_total++; if (en_cnt !== 1) begin n_bad++; $display("FAIL lat3_en_pulse: got %0d want 1", en_cnt); end
    n_total++; if (l3_rsp_sum !== 9'd150 || l3_rsp_id !== 2'd0) begin n_bad++; $display("FAIL lat3_rsp: got id=%0d sum=%0d want 0/150", l3_rsp_id, l3_rsp_sum); end
    tick();
    $display("test_lat3 done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_in_wait();
    test_carry();
    test_lat3();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
